// File: rtl/sc_counter_pkg.sv
// Shared definitions for the up/down transition counter family: count modes,
// the per-cycle event encoding and the helper that builds it.
package sc_counter_pkg;

  localparam int SC_MODE_WRAP = 0;
  localparam int SC_MODE_SAT  = 1;

  typedef enum logic [1:0] {
    SC_EV_NONE   = 2'b00,
    SC_EV_UP     = 2'b01,
    SC_EV_DOWN   = 2'b10,
    SC_EV_CANCEL = 2'b11
  } sc_event_e;

  // Simultaneous up and down collapse into a single CANCEL code.
  function automatic sc_event_e sc_encode_event(input logic upEvent, input logic downEvent);
    sc_event_e code;
    case ({downEvent, upEvent})
      2'b01:   code = SC_EV_UP;
      2'b10:   code = SC_EV_DOWN;
      2'b11:   code = SC_EV_CANCEL;
      default: code = SC_EV_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sc_transition_detector.sv
// Synchronises an active-low asynchronous button and flags one event per
// high-to-low transition, ignoring a button already low when reset releases.
module sc_transition_detector
  import sc_counter_pkg::*;
(
  input  logic SC_TRANSITIONDETECTOR_CLOCK_50,
  input  logic SC_TRANSITIONDETECTOR_RESET_InLow,
  input  logic SC_TRANSITIONDETECTOR_button_InLow,
  output logic SC_TRANSITIONDETECTOR_event_OutHigh
);

  logic       sync1_r;
  logic       sync2_r;
  logic       prev_r;
  logic       arm_r;
  logic [1:0] fill_r;

  // Synchroniser, edge history and arming; fill_r marks when sync2_r holds real input rather than its reset value.
  always_ff @(posedge SC_TRANSITIONDETECTOR_CLOCK_50) begin
    if (!SC_TRANSITIONDETECTOR_RESET_InLow) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
      arm_r   <= 1'b0;
      fill_r  <= 2'b00;
    end else begin
      sync1_r <= SC_TRANSITIONDETECTOR_button_InLow;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      arm_r   <= arm_r | (fill_r[1] & sync2_r);
      fill_r  <= {fill_r[0], 1'b1};
    end
  end

  assign SC_TRANSITIONDETECTOR_event_OutHigh = arm_r & prev_r & ~sync2_r;

endmodule

// File: rtl/sc_updown_transition_counter.sv
// Parametrised up/down counter driven by debounced-by-edge button events,
// with clear/load priority and registered overflow, underflow and zero flags.
module sc_updown_transition_counter
  import sc_counter_pkg::*;
#(
  parameter int              DATAWIDTH = 8,
  parameter longint unsigned MAXVALUE  = (64'd1 << DATAWIDTH) - 64'd1,
  parameter int              SATURATE  = 0
) (
  input  logic                 SC_UDTRANSITIONCOUNTER_CLOCK_50,
  input  logic                 SC_UDTRANSITIONCOUNTER_RESET_InLow,
  input  logic                 SC_UDTRANSITIONCOUNTER_upcount_InLow,
  input  logic                 SC_UDTRANSITIONCOUNTER_downcount_InLow,
  input  logic                 SC_UDTRANSITIONCOUNTER_clear_InLow,
  input  logic                 SC_UDTRANSITIONCOUNTER_load_InLow,
  input  logic [DATAWIDTH-1:0] SC_UDTRANSITIONCOUNTER_data_InBUS,
  output logic [DATAWIDTH-1:0] SC_UDTRANSITIONCOUNTER_data_OutBUS,
  output logic                 SC_UDTRANSITIONCOUNTER_overflow_OutHigh,
  output logic                 SC_UDTRANSITIONCOUNTER_underflow_OutHigh,
  output logic                 SC_UDTRANSITIONCOUNTER_zero_OutHigh
);

  generate
    if (MAXVALUE > ((64'd1 << DATAWIDTH) - 64'd1)) begin : gMaxValueCheck
      $error("MAXVALUE does not fit in DATAWIDTH bits");
    end
  endgenerate

  localparam logic [DATAWIDTH-1:0] MAX_C  = MAXVALUE[DATAWIDTH-1:0];
  localparam logic [DATAWIDTH-1:0] ZERO_C = {DATAWIDTH{1'b0}};
  localparam logic [DATAWIDTH-1:0] ONE_C  = {{(DATAWIDTH-1){1'b0}}, 1'b1};

  logic                 upEvent_s;
  logic                 downEvent_s;
  sc_event_e            event_s;
  logic [DATAWIDTH-1:0] nextCount_s;
  logic                 nextOverflow_s;
  logic                 nextUnderflow_s;
  logic [DATAWIDTH-1:0] count_r;
  logic                 overflow_r;
  logic                 underflow_r;
  logic                 zero_r;

  sc_transition_detector uUpDetector (
    .SC_TRANSITIONDETECTOR_CLOCK_50     (SC_UDTRANSITIONCOUNTER_CLOCK_50),
    .SC_TRANSITIONDETECTOR_RESET_InLow  (SC_UDTRANSITIONCOUNTER_RESET_InLow),
    .SC_TRANSITIONDETECTOR_button_InLow (SC_UDTRANSITIONCOUNTER_upcount_InLow),
    .SC_TRANSITIONDETECTOR_event_OutHigh(upEvent_s)
  );

  sc_transition_detector uDownDetector (
    .SC_TRANSITIONDETECTOR_CLOCK_50     (SC_UDTRANSITIONCOUNTER_CLOCK_50),
    .SC_TRANSITIONDETECTOR_RESET_InLow  (SC_UDTRANSITIONCOUNTER_RESET_InLow),
    .SC_TRANSITIONDETECTOR_button_InLow (SC_UDTRANSITIONCOUNTER_downcount_InLow),
    .SC_TRANSITIONDETECTOR_event_OutHigh(downEvent_s)
  );

  assign event_s = sc_encode_event(upEvent_s, downEvent_s);

  // Priority mux: clear over load over counting; range ends wrap or hold by SATURATE.
  always_comb begin
    nextCount_s     = count_r;
    nextOverflow_s  = 1'b0;
    nextUnderflow_s = 1'b0;
    if (!SC_UDTRANSITIONCOUNTER_clear_InLow) begin
      nextCount_s = ZERO_C;
    end else if (!SC_UDTRANSITIONCOUNTER_load_InLow) begin
      if (SC_UDTRANSITIONCOUNTER_data_InBUS > MAX_C) begin
        nextCount_s = MAX_C;
      end else begin
        nextCount_s = SC_UDTRANSITIONCOUNTER_data_InBUS;
      end
    end else begin
      case (event_s)
        SC_EV_UP: begin
          if (count_r == MAX_C) begin
            nextOverflow_s = 1'b1;
            nextCount_s    = (SATURATE == SC_MODE_SAT) ? MAX_C : ZERO_C;
          end else begin
            nextCount_s = count_r + ONE_C;
          end
        end
        SC_EV_DOWN: begin
          if (count_r == ZERO_C) begin
            nextUnderflow_s = 1'b1;
            nextCount_s     = (SATURATE == SC_MODE_SAT) ? ZERO_C : MAX_C;
          end else begin
            nextCount_s = count_r - ONE_C;
          end
        end
        default: nextCount_s = count_r;
      endcase
    end
  end

  // Count and flag registers, all updated together.
  always_ff @(posedge SC_UDTRANSITIONCOUNTER_CLOCK_50) begin
    if (!SC_UDTRANSITIONCOUNTER_RESET_InLow) begin
      count_r     <= ZERO_C;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      zero_r      <= 1'b1;
    end else begin
      count_r     <= nextCount_s;
      overflow_r  <= nextOverflow_s;
      underflow_r <= nextUnderflow_s;
      zero_r      <= (nextCount_s == ZERO_C);
    end
  end

  assign SC_UDTRANSITIONCOUNTER_data_OutBUS       = count_r;
  assign SC_UDTRANSITIONCOUNTER_overflow_OutHigh  = overflow_r;
  assign SC_UDTRANSITIONCOUNTER_underflow_OutHigh = underflow_r;
  assign SC_UDTRANSITIONCOUNTER_zero_OutHigh      = zero_r;

endmodule

// File: tb/tb_sc_updown_transition_counter.sv
// Directed bench for three counter configurations: 8-bit wrap, MAXVALUE=9 wrap
// and MAXVALUE=9 saturate, sharing clock, reset, clear and load.
module tb_sc_updown_transition_counter;

  logic       clk_s = 1'b0;
  logic       reset_s = 1'b0;
  logic       clear_s = 1'b1;
  logic       load_s = 1'b1;
  logic [7:0] data_s = 8'd0;
  logic [2:0] up_s = 3'b111;
  logic [2:0] down_s = 3'b111;
  logic [7:0] cnt_s [3];
  logic [2:0] ovf_s;
  logic [2:0] unf_s;
  logic [2:0] zero_s;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk_s = ~clk_s;

  sc_updown_transition_counter #(.DATAWIDTH(8), .SATURATE(0)) uDutA (
    .SC_UDTRANSITIONCOUNTER_CLOCK_50(clk_s), .SC_UDTRANSITIONCOUNTER_RESET_InLow(reset_s),
    .SC_UDTRANSITIONCOUNTER_upcount_InLow(up_s[0]), .SC_UDTRANSITIONCOUNTER_downcount_InLow(down_s[0]),
    .SC_UDTRANSITIONCOUNTER_clear_InLow(clear_s), .SC_UDTRANSITIONCOUNTER_load_InLow(load_s),
    .SC_UDTRANSITIONCOUNTER_data_InBUS(data_s), .SC_UDTRANSITIONCOUNTER_data_OutBUS(cnt_s[0]),
    .SC_UDTRANSITIONCOUNTER_overflow_OutHigh(ovf_s[0]), .SC_UDTRANSITIONCOUNTER_underflow_OutHigh(unf_s[0]),
    .SC_UDTRANSITIONCOUNTER_zero_OutHigh(zero_s[0])
  );

  sc_updown_transition_counter #(.DATAWIDTH(8), .MAXVALUE(64'd9), .SATURATE(0)) uDutB (
    .SC_UDTRANSITIONCOUNTER_CLOCK_50(clk_s), .SC_UDTRANSITIONCOUNTER_RESET_InLow(reset_s),
    .SC_UDTRANSITIONCOUNTER_upcount_InLow(up_s[1]), .SC_UDTRANSITIONCOUNTER_downcount_InLow(down_s[1]),
    .SC_UDTRANSITIONCOUNTER_clear_InLow(clear_s), .SC_UDTRANSITIONCOUNTER_load_InLow(load_s),
    .SC_UDTRANSITIONCOUNTER_data_InBUS(data_s), .SC_UDTRANSITIONCOUNTER_data_OutBUS(cnt_s[1]),
    .SC_UDTRANSITIONCOUNTER_overflow_OutHigh(ovf_s[1]), .SC_UDTRANSITIONCOUNTER_underflow_OutHigh(unf_s[1]),
    .SC_UDTRANSITIONCOUNTER_zero_OutHigh(zero_s[1])
  );

  sc_updown_transition_counter #(.DATAWIDTH(8), .MAXVALUE(64'd9), .SATURATE(1)) uDutC (
    .SC_UDTRANSITIONCOUNTER_CLOCK_50(clk_s), .SC_UDTRANSITIONCOUNTER_RESET_InLow(reset_s),
    .SC_UDTRANSITIONCOUNTER_upcount_InLow(up_s[2]), .SC_UDTRANSITIONCOUNTER_downcount_InLow(down_s[2]),
    .SC_UDTRANSITIONCOUNTER_clear_InLow(clear_s), .SC_UDTRANSITIONCOUNTER_load_InLow(load_s),
    .SC_UDTRANSITIONCOUNTER_data_InBUS(data_s), .SC_UDTRANSITIONCOUNTER_data_OutBUS(cnt_s[2]),
    .SC_UDTRANSITIONCOUNTER_overflow_OutHigh(ovf_s[2]), .SC_UDTRANSITIONCOUNTER_underflow_OutHigh(unf_s[2]),
    .SC_UDTRANSITIONCOUNTER_zero_OutHigh(zero_s[2])
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_s);
      #1;
    end
  endtask

  task automatic check_state(input string tag, input int idx, input int expCount,
                             input bit expOvf, input bit expUnf);
    check_value({tag, " count"}, 32'(cnt_s[idx]), 32'(expCount));
    check_value({tag, " ovf"}, 32'(ovf_s[idx]), 32'(expOvf));
    check_value({tag, " unf"}, 32'(unf_s[idx]), 32'(expUnf));
    check_value({tag, " zero"}, 32'(zero_s[idx]), (expCount == 0) ? 32'd1 : 32'd0);
  endtask

  // One press: low for 5 cycles, high for 5; result expected on the 3rd edge after driving low.
  task automatic press_check(input string tag, input int idx, input bit isUp, input int prevCount,
                             input int expCount, input bit expOvf, input bit expUnf);
    if (isUp) up_s[idx] = 1'b0; else down_s[idx] = 1'b0;
    tick(2);
    check_state({tag, " hold"}, idx, prevCount, 1'b0, 1'b0);
    tick(1);
    check_state({tag, " step"}, idx, expCount, expOvf, expUnf);
    tick(1);
    check_state({tag, " after"}, idx, expCount, 1'b0, 1'b0);
    tick(1);
    if (isUp) up_s[idx] = 1'b1; else down_s[idx] = 1'b1;
    tick(5);
  endtask

  task automatic do_load(input logic [7:0] value);
    data_s = value;
    load_s = 1'b0;
    tick(1);
    load_s = 1'b1;
  endtask

  initial begin
    tick(3);
    for (int i = 0; i < 3; i++) check_state("reset", i, 0, 1'b0, 1'b0);
    reset_s = 1'b1;
    tick(4);

    // MAXVALUE=9 wrap
    do_load(8'd9);
    check_value("B load9", 32'(cnt_s[1]), 32'd9);
    press_check("B wrap up", 1, 1'b1, 9, 0, 1'b1, 1'b0);
    press_check("B wrap down", 1, 1'b0, 0, 9, 1'b0, 1'b1);

    // MAXVALUE=9 saturate
    press_check("C sat up", 2, 1'b1, 9, 9, 1'b1, 1'b0);
    clear_s = 1'b0;
    tick(1);
    clear_s = 1'b1;
    check_state("C clear", 2, 0, 1'b0, 1'b0);
    check_state("A clear", 0, 0, 1'b0, 1'b0);
    press_check("C sat down", 2, 1'b0, 0, 0, 1'b0, 1'b1);
    do_load(8'd200);
    check_value("C load200", 32'(cnt_s[2]), 32'd9);
    check_value("B load200", 32'(cnt_s[1]), 32'd9);
    check_value("A load200", 32'(cnt_s[0]), 32'd200);

    // 8-bit wrap: three presses from zero
    clear_s = 1'b0;
    tick(1);
    clear_s = 1'b1;
    press_check("A up1", 0, 1'b1, 0, 1, 1'b0, 1'b0);
    press_check("A up2", 0, 1'b1, 1, 2, 1'b0, 1'b0);
    press_check("A up3", 0, 1'b1, 2, 3, 1'b0, 1'b0);
    press_check("A down", 0, 1'b0, 3, 2, 1'b0, 1'b0);

    // Simultaneous up and down cancel
    do_load(8'd5);
    up_s[0] = 1'b0;
    down_s[0] = 1'b0;
    tick(3);
    check_state("A cancel", 0, 5, 1'b0, 1'b0);
    tick(2);
    up_s[0] = 1'b1;
    down_s[0] = 1'b1;
    tick(5);
    check_state("A cancel end", 0, 5, 1'b0, 1'b0);

    // Load wins over an up event in the same cycle
    up_s[0] = 1'b0;
    tick(2);
    data_s = 8'd7;
    load_s = 1'b0;
    tick(1);
    load_s = 1'b1;
    check_state("A load vs up", 0, 7, 1'b0, 1'b0);
    tick(2);
    up_s[0] = 1'b1;
    tick(5);
    check_state("A load vs up end", 0, 7, 1'b0, 1'b0);

    // Up held low through reset release never counts
    up_s[0] = 1'b0;
    tick(1);
    reset_s = 1'b0;
    tick(3);
    check_state("A reset held", 0, 0, 1'b0, 1'b0);
    reset_s = 1'b1;
    tick(8);
    check_state("A held low", 0, 0, 1'b0, 1'b0);
    up_s[0] = 1'b1;
    tick(5);
    press_check("A after held", 0, 1'b1, 0, 1, 1'b0, 1'b0);

    // Press in flight is lost when reset follows one cycle later
    up_s[0] = 1'b0;
    tick(1);
    reset_s = 1'b0;
    tick(3);
    check_state("A reset in flight", 0, 0, 1'b0, 1'b0);
    reset_s = 1'b1;
    tick(5);
    up_s[0] = 1'b1;
    tick(5);
    check_state("A in flight lost", 0, 0, 1'b0, 1'b0);

    // 8-bit range ends
    press_check("A underflow", 0, 1'b0, 0, 255, 1'b0, 1'b1);
    press_check("A overflow", 0, 1'b1, 255, 0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
